// File: rtl/issue_scoreboard_if.sv
// ============================================================================
// Module   : issue_scoreboard_if
// Brief    : Issue, FU-completion and writeback bundle of the issue scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface issue_scoreboard_if #(
    parameter int NUM_FU   = 5,
    parameter int NUM_REGS = 32
);
    logic                issue_valid;
    logic [2:0]          issue_fu;
    logic [4:0]          issue_rd;
    logic                issue_rd_we;
    logic [4:0]          issue_rs1;
    logic [4:0]          issue_rs2;
    logic                issue_rs1_use;
    logic                issue_rs2_use;
    logic                issue_ready;
    logic [NUM_FU-1:0]   fu_en;
    logic [NUM_FU-1:0]   fu_finish;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic [2:0]          wb_sel;
    logic [NUM_FU-1:0]   fu_busy;
    logic [NUM_REGS-1:0] reg_pending;

    modport master (
        output issue_valid, issue_fu, issue_rd, issue_rd_we,
               issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use, fu_finish,
        input  issue_ready, fu_en, wb_valid, wb_rd, wb_sel, fu_busy, reg_pending
    );

    modport slave (
        input  issue_valid, issue_fu, issue_rd, issue_rd_we,
               issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use, fu_finish,
        output issue_ready, fu_en, wb_valid, wb_rd, wb_sel, fu_busy, reg_pending
    );
endinterface

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// Module   : issue_scoreboard
// Brief    : FU occupancy / register-pending scoreboard with hazard-stalled
//            issue and fixed-priority serialisation of FU writebacks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module issue_scoreboard #(
    parameter int NUM_FU   = 5,
    parameter int NUM_REGS = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    issue_scoreboard_if.slave  sb
);
    localparam int c_JUMP_IDX = 4;

    logic [NUM_FU-1:0]   busy_q, busy_d;
    logic [NUM_FU-1:0]   done_q, done_d;
    logic [NUM_FU-1:0]   wen_q, wen_d;
    logic [4:0]          dest_q [NUM_FU];
    logic [4:0]          dest_d [NUM_FU];
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic [NUM_FU-1:0]   w_tgt;
    logic                w_tgt_valid;
    logic                w_tgt_busy;
    logic                w_raw;
    logic                w_issue_wen;
    logic                w_waw;
    logic                w_issue_ready;

    logic [NUM_FU-1:0]   w_gnt;
    logic                w_gnt_any;
    logic [2:0]          w_gnt_sel;
    logic [4:0]          w_gnt_rd;
    logic                w_gnt_wen;

    // Indices beyond the last FU decode to no target and are never accepted.
    always_comb begin
        w_tgt = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (sb.issue_fu == 3'(f)) begin
                w_tgt[f] = 1'b1;
            end
        end
        w_tgt_valid   = |w_tgt;
        w_tgt_busy    = |(w_tgt & busy_q);
        w_raw         = (sb.issue_rs1_use & pending_q[sb.issue_rs1]) |
                        (sb.issue_rs2_use & pending_q[sb.issue_rs2]);
        w_issue_wen   = sb.issue_rd_we & (sb.issue_rd != 5'd0);
        w_waw         = w_issue_wen & pending_q[sb.issue_rd];
        w_issue_ready = sb.issue_valid & w_tgt_valid & ~w_tgt_busy &
                        ~busy_q[c_JUMP_IDX] & ~w_raw & ~w_waw;
    end

    // Descending scan so the lowest-index done FU is the last one to win.
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_sel = 3'd0;
        w_gnt_rd  = 5'd0;
        w_gnt_wen = 1'b0;
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (done_q[f]) begin
                w_gnt     = '0;
                w_gnt[f]  = 1'b1;
                w_gnt_any = 1'b1;
                w_gnt_sel = 3'(f + 1);
                w_gnt_rd  = dest_q[f];
                w_gnt_wen = wen_q[f];
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q | (sb.fu_finish & busy_q);
        wen_d     = wen_q;
        dest_d    = dest_q;
        pending_d = pending_q;

        if (w_gnt_any) begin
            busy_d = busy_d & ~w_gnt;
            done_d = done_d & ~w_gnt;
            if (w_gnt_wen) begin
                pending_d[w_gnt_rd] = 1'b0;
            end
        end

        // The issue target is never the retiring FU: it is still busy.
        if (w_issue_ready) begin
            busy_d = busy_d | w_tgt;
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_tgt[f]) begin
                    dest_d[f] = sb.issue_rd;
                    wen_d[f]  = w_issue_wen;
                end
            end
            if (w_issue_wen) begin
                pending_d[sb.issue_rd] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= '0;
            done_q    <= '0;
            wen_q     <= '0;
            pending_q <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                dest_q[f] <= 5'd0;
            end
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            wen_q     <= wen_d;
            pending_q <= pending_d;
            for (int f = 0; f < NUM_FU; f++) begin
                dest_q[f] <= dest_d[f];
            end
        end
    end

    assign sb.issue_ready = w_issue_ready;
    assign sb.fu_en       = w_tgt & {NUM_FU{w_issue_ready}};
    assign sb.wb_valid    = w_gnt_any & w_gnt_wen;
    assign sb.wb_rd       = w_gnt_rd;
    assign sb.wb_sel      = w_gnt_sel;
    assign sb.fu_busy     = busy_q;
    assign sb.reg_pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// Module   : tb_issue_scoreboard
// Brief    : Directed stimulus with a writeback scoreboard queue and monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;
    typedef struct packed {
        logic [2:0] sel;
        logic [4:0] rd;
        logic       v;
    } wb_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    wb_t  exp_q [$];

    issue_scoreboard_if #(.NUM_FU(5), .NUM_REGS(32)) sb_if ();

    issue_scoreboard #(.NUM_FU(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] fu, input logic [4:0] rd, input logic we,
                         input logic [4:0] rs1, input logic u1);
        sb_if.issue_valid   = 1'b1;
        sb_if.issue_fu      = fu;
        sb_if.issue_rd      = rd;
        sb_if.issue_rd_we   = we;
        sb_if.issue_rs1     = rs1;
        sb_if.issue_rs1_use = u1;
        sb_if.issue_rs2     = 5'd0;
        sb_if.issue_rs2_use = 1'b0;
        #1;
    endtask

    task automatic no_issue();
        sb_if.issue_valid   = 1'b0;
        sb_if.issue_rs1_use = 1'b0;
        sb_if.issue_rs2_use = 1'b0;
        #1;
    endtask

    task automatic expect_wb(input logic [2:0] sel, input logic [4:0] rd, input logic v);
        wb_t e;
        e.sel = sel;
        e.rd  = rd;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // Every grant is sampled mid-cycle and matched against the queue head.
    always @(negedge clk) begin
        if (sb_if.wb_sel != 3'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant_sel", {29'd0, sb_if.wb_sel}, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_sel",   {29'd0, sb_if.wb_sel}, {29'd0, e.sel});
                check("wb_rd",    {27'd0, sb_if.wb_rd},  {27'd0, e.rd});
                check("wb_valid", {31'd0, sb_if.wb_valid}, {31'd0, e.v});
            end
        end else begin
            check("wb_valid_idle", {31'd0, sb_if.wb_valid}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        sb_if.issue_fu  = 3'd0;
        sb_if.issue_rd  = 5'd0;
        sb_if.issue_rd_we = 1'b0;
        sb_if.issue_rs1 = 5'd0;
        sb_if.issue_rs2 = 5'd0;
        sb_if.fu_finish = 5'h1F;
        no_issue();

        // Reset with spurious finishes
        step();
        step();
        check("rst_fu_busy", {27'd0, sb_if.fu_busy}, 32'd0);
        check("rst_pending", sb_if.reg_pending, 32'd0);
        check("rst_wb_valid", {31'd0, sb_if.wb_valid}, 32'd0);
        check("rst_wb_sel", {29'd0, sb_if.wb_sel}, 32'd0);
        rst = 1'b1;
        sb_if.fu_finish = 5'd0;
        step();

        // Independent overlap: DIV x5, MUL x6, ALU x7
        issue(3'd3, 5'd5, 1'b1, 5'd0, 1'b0);
        check("ovl_div_en", {27'd0, sb_if.fu_en}, 32'h08);
        step();
        issue(3'd2, 5'd6, 1'b1, 5'd0, 1'b0);
        check("ovl_mul_en", {27'd0, sb_if.fu_en}, 32'h04);
        step();
        issue(3'd0, 5'd7, 1'b1, 5'd0, 1'b0);
        check("ovl_alu_en", {27'd0, sb_if.fu_en}, 32'h01);
        step();
        no_issue();
        check("ovl_pending", sb_if.reg_pending, 32'h0000_00E0);
        check("ovl_busy", {27'd0, sb_if.fu_busy}, 32'h0D);

        // Simultaneous finish of ALU, MUL, DIV
        sb_if.fu_finish = 5'b01101;
        expect_wb(3'd1, 5'd7, 1'b1);
        expect_wb(3'd3, 5'd6, 1'b1);
        expect_wb(3'd4, 5'd5, 1'b1);
        step();
        sb_if.fu_finish = 5'd0;
        step();
        step();
        step();
        check("sim_busy_free", {27'd0, sb_if.fu_busy}, 32'd0);
        check("sim_pending_free", sb_if.reg_pending, 32'd0);

        // RAW stall on x5 behind DIV
        issue(3'd3, 5'd5, 1'b1, 5'd0, 1'b0);
        check("raw_div_en", {27'd0, sb_if.fu_en}, 32'h08);
        step();
        issue(3'd0, 5'd8, 1'b1, 5'd5, 1'b1);
        check("raw_stall0", {31'd0, sb_if.issue_ready}, 32'd0);
        check("raw_stall0_en", {27'd0, sb_if.fu_en}, 32'd0);
        step();
        sb_if.fu_finish = 5'b01000;
        #1;
        expect_wb(3'd4, 5'd5, 1'b1);
        check("raw_stall_fin", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        sb_if.fu_finish = 5'd0;
        #1;
        check("raw_stall_grant", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        check("raw_accept", {31'd0, sb_if.issue_ready}, 32'd1);
        check("raw_accept_en", {27'd0, sb_if.fu_en}, 32'h01);
        step();
        no_issue();
        sb_if.fu_finish = 5'b00001;
        expect_wb(3'd1, 5'd8, 1'b1);
        step();
        sb_if.fu_finish = 5'd0;
        step();
        step();

        // WAW on x6 and writes to x0
        issue(3'd2, 5'd6, 1'b1, 5'd0, 1'b0);
        check("waw_mul_en", {27'd0, sb_if.fu_en}, 32'h04);
        step();
        issue(3'd0, 5'd6, 1'b1, 5'd0, 1'b0);
        check("waw_stall", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        issue(3'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        check("x0_accept_en", {27'd0, sb_if.fu_en}, 32'h01);
        step();
        no_issue();
        check("x0_pending", sb_if.reg_pending, 32'h0000_0040);
        check("x0_busy", {27'd0, sb_if.fu_busy}, 32'h05);
        sb_if.fu_finish = 5'b00101;
        expect_wb(3'd1, 5'd0, 1'b0);
        expect_wb(3'd3, 5'd6, 1'b1);
        step();
        sb_if.fu_finish = 5'd0;
        step();
        step();

        // Out-of-range FU indices
        issue(3'd5, 5'd3, 1'b1, 5'd0, 1'b0);
        check("fu5_ready", {31'd0, sb_if.issue_ready}, 32'd0);
        issue(3'd7, 5'd3, 1'b1, 5'd0, 1'b0);
        check("fu7_en", {27'd0, sb_if.fu_en}, 32'd0);
        step();

        // JUMP blocks all issue until it retires
        issue(3'd4, 5'd1, 1'b1, 5'd0, 1'b0);
        check("jmp_en", {27'd0, sb_if.fu_en}, 32'h10);
        step();
        issue(3'd0, 5'd9, 1'b1, 5'd0, 1'b0);
        check("jmp_block0", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        sb_if.fu_finish = 5'b10000;
        #1;
        expect_wb(3'd5, 5'd1, 1'b1);
        check("jmp_block_fin", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        sb_if.fu_finish = 5'd0;
        #1;
        check("jmp_block_grant", {31'd0, sb_if.issue_ready}, 32'd0);
        step();
        check("jmp_after_en", {27'd0, sb_if.fu_en}, 32'h01);
        step();
        issue(3'd3, 5'd10, 1'b1, 5'd0, 1'b0);
        check("mid_div_en", {27'd0, sb_if.fu_en}, 32'h08);
        step();
        no_issue();
        check("mid_pending", sb_if.reg_pending, 32'h0000_0600);
        check("mid_busy", {27'd0, sb_if.fu_busy}, 32'h09);

        // Reset in the middle of outstanding work drops everything
        rst = 1'b0;
        sb_if.fu_finish = 5'b01001;
        step();
        rst = 1'b1;
        sb_if.fu_finish = 5'd0;
        #1;
        check("mrst_busy", {27'd0, sb_if.fu_busy}, 32'd0);
        check("mrst_pending", sb_if.reg_pending, 32'd0);
        check("mrst_wb_sel", {29'd0, sb_if.wb_sel}, 32'd0);
        check("mrst_wb_rd", {27'd0, sb_if.wb_rd}, 32'd0);
        issue(3'd0, 5'd9, 1'b1, 5'd9, 1'b1);
        check("mrst_issue_ready", {31'd0, sb_if.issue_ready}, 32'd1);
        step();
        no_issue();
        sb_if.fu_finish = 5'b00001;
        expect_wb(3'd1, 5'd9, 1'b1);
        step();
        sb_if.fu_finish = 5'd0;
        step();
        step();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
